regdump_uart_tx: RTL and testbench



---
 rtl/regdump_pkg.sv | 26 ++
 rtl/uart_tx_byte.sv | 62 ++++++
 rtl/regdump_uart_tx.sv | 127 ++++++++++++
 tb/tb_regdump_uart_tx.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regdump_pkg.sv
// Shared types and constants for the register-dump UART engine.
// The dump FSM and the byte transmitter both import this package.
package regdump_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    SEL,
    CAP,
    SEND,
    FIN
  } dump_state_t;

  localparam bit   MSB_FIRST      = 1'b1;
  localparam logic START_BIT      = 1'b0;
  localparam logic STOP_BIT       = 1'b1;
  localparam int   BITS_PER_FRAME = 10;

  // Byte bc of a captured word in transmit order (bc=0 is sent first).
  function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] bc);
    logic [1:0] lane;
    lane = MSB_FIRST ? (2'd3 - bc) : bc;
    return word[{lane, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte transmitter with a valid/ready input; one idle (ready) cycle of
// tx=1 separates consecutive frames.
module uart_tx_byte
  import regdump_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx
);

  localparam int             TW        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0]  LAST_TICK = TW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]     LAST_BIT  = 4'(BITS_PER_FRAME - 1);

  logic          active;
  logic [TW-1:0] bit_timer;
  logic [3:0]    bit_cnt;   // 0 = start, 1..8 = data, 9 = stop
  logic [7:0]    shreg;

  assign ready = ~active;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      active    <= 1'b0;
      bit_timer <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      tx        <= STOP_BIT;
    end else if (!active) begin
      if (valid) begin
        active    <= 1'b1;
        bit_timer <= '0;
        bit_cnt   <= '0;
        shreg     <= data;
        tx        <= START_BIT;
      end
    end else if (bit_timer != LAST_TICK) begin
      bit_timer <= bit_timer + 1'b1;
    end else begin
      bit_timer <= '0;
      if (bit_cnt == LAST_BIT) begin
        active <= 1'b0;
      end else begin
        bit_cnt <= bit_cnt + 4'd1;
        if (bit_cnt == LAST_BIT - 4'd1) begin
          tx <= STOP_BIT;
        end else begin
          tx    <= shreg[0];
          shreg <= shreg >> 1;
        end
      end
    end
  end

endmodule

// File: rtl/regdump_uart_tx.sv
// Debug register-dump engine: walks the CPU debug read port and streams a
// sync byte followed by every register (MSB byte first) over an 8N1 UART.
module regdump_uart_tx
  import regdump_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 16,
  parameter int         NUM_REGS     = 32,
  parameter int         SETTLE       = 1,
  parameter logic [7:0] SYNC_BYTE    = 8'h5A
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  output logic [4:0]  reg_sel,
  input  logic [31:0] reg_data,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam logic [4:0] LAST_IDX    = 5'(NUM_REGS - 1);
  localparam logic [3:0] LAST_SETTLE = 4'(SETTLE - 1);

  dump_state_t state;
  logic [4:0]  idx;
  logic [1:0]  bc;
  logic [3:0]  settle_cnt;
  logic [31:0] shadow;
  logic        byte_valid;
  logic        byte_ready;
  logic [7:0]  byte_data;
  logic        accept;

  // NOTE: a fully specified conditional assign cannot infer a latch.
  assign byte_data = (state == HDR) ? SYNC_BYTE : word_byte(shadow, bc);
  assign accept    = byte_valid & byte_ready;

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk  (clk),
    .rstn (rstn),
    .data (byte_data),
    .valid(byte_valid),
    .ready(byte_ready),
    .tx   (tx)
  );

  // NOTE: shadow is a plain register, not a memory array, so it is reset
  // with the rest of the state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      idx        <= '0;
      bc         <= '0;
      settle_cnt <= '0;
      shadow     <= '0;
      reg_sel    <= '0;
      byte_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          // The done cycle is still IDLE; a start landing on it is dropped.
          if (start && !done) begin
            state      <= HDR;
            busy       <= 1'b1;
            byte_valid <= 1'b1;
          end
        end
        HDR: begin
          if (accept) begin
            byte_valid <= 1'b0;
            idx        <= '0;
            reg_sel    <= '0;
            settle_cnt <= '0;
            state      <= SEL;
          end
        end
        SEL: begin
          if (settle_cnt == LAST_SETTLE) begin
            settle_cnt <= '0;
            state      <= CAP;
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end
        CAP: begin
          shadow     <= reg_data;
          bc         <= '0;
          byte_valid <= 1'b1;
          state      <= SEND;
        end
        SEND: begin
          if (accept) begin
            if (bc == 2'd3) begin
              byte_valid <= 1'b0;
              if (idx == LAST_IDX) begin
                state <= FIN;
              end else begin
                idx        <= idx + 5'd1;
                reg_sel    <= idx + 5'd1;
                settle_cnt <= '0;
                state      <= SEL;
              end
            end else begin
              bc <= bc + 2'd1;
            end
          end
        end
        FIN: begin
          if (byte_ready) begin
            done    <= 1'b1;
            busy    <= 1'b0;
            idx     <= '0;
            reg_sel <= '0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regdump_uart_tx.sv
// Scoreboard bench for regdump_uart_tx: a full-size instance (32 regs) and a
// two-register instance, both decoded by a UART receiver model.
module tb_regdump_uart_tx;

  localparam int CPB = 4;
  typedef logic [7:0] byte_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start_a, start_b;
  logic [4:0]  reg_sel_a, reg_sel_b;
  logic [31:0] reg_data_a, reg_data_b;
  logic        tx_a, tx_b, busy_a, busy_b, done_a, done_b;

  logic [31:0] regs_a [32];
  logic [31:0] regs_b [2];

  byte_t exp_a[$], rx_a[$], exp_b[$], rx_b[$];
  int    n_vec = 0, n_err = 0;
  int    frame_err_a = 0, frame_err_b = 0;
  int    done_cnt_a = 0, done_cnt_b = 0;
  logic  busy_at_done_b, busy_before_done_b, prev_busy_b;

  always #5 clk = ~clk;

  assign reg_data_a = regs_a[reg_sel_a];
  assign reg_data_b = regs_b[reg_sel_b[0]];

  regdump_uart_tx #(.CLKS_PER_BIT(CPB), .NUM_REGS(32), .SETTLE(1), .SYNC_BYTE(8'h5A)) dut_a (
    .clk(clk), .rstn(rstn), .start(start_a), .reg_sel(reg_sel_a), .reg_data(reg_data_a),
    .tx(tx_a), .busy(busy_a), .done(done_a));

  regdump_uart_tx #(.CLKS_PER_BIT(CPB), .NUM_REGS(2), .SETTLE(2), .SYNC_BYTE(8'h5A)) dut_b (
    .clk(clk), .rstn(rstn), .start(start_b), .reg_sel(reg_sel_b), .reg_data(reg_data_b),
    .tx(tx_b), .busy(busy_b), .done(done_b));

  function automatic logic line_of(input bit sel);
    return sel ? tx_b : tx_a;
  endfunction

  // Receiver model: samples mid-bit on negedges; a reset abandons the frame.
  task automatic uart_mon(input bit sel);
    byte_t b;
    bit    ok;
    forever begin
      @(negedge clk);
      if (rstn === 1'b1 && line_of(sel) === 1'b0) begin
        ok = 1'b1;
        b  = '0;
        for (int k = 0; k <= 9; k++) begin
          repeat ((k == 0) ? CPB / 2 : CPB) begin
            @(negedge clk);
            if (rstn !== 1'b1) ok = 1'b0;
          end
          if (!ok) break;
          if (k == 0 && line_of(sel) !== 1'b0) begin
            if (sel) frame_err_b++; else frame_err_a++;
            ok = 1'b0;
            break;
          end
          if (k >= 1 && k <= 8) b[k-1] = line_of(sel);
          if (k == 9 && line_of(sel) !== 1'b1) begin
            if (sel) frame_err_b++; else frame_err_a++;
          end
        end
        if (ok) begin
          if (sel) rx_b.push_back(b); else rx_a.push_back(b);
        end
      end
    end
  endtask

  initial uart_mon(1'b0);
  initial uart_mon(1'b1);

  initial begin
    prev_busy_b = 1'b0;
    forever begin
      @(negedge clk);
      if (done_a === 1'b1) done_cnt_a++;
      if (done_b === 1'b1) begin
        done_cnt_b++;
        busy_at_done_b     = busy_b;
        busy_before_done_b = prev_busy_b;
      end
      prev_busy_b = busy_b;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, summary not reached");
    $fatal(1, "watchdog");
  end

  task automatic push_expected_a();
    logic [31:0] w;
    exp_a.push_back(8'h5A);
    for (int r = 0; r < 32; r++) begin
      w = regs_a[r];
      exp_a.push_back(w[31:24]); exp_a.push_back(w[23:16]);
      exp_a.push_back(w[15:8]);  exp_a.push_back(w[7:0]);
    end
  endtask

  task automatic push_expected_b();
    logic [31:0] w;
    exp_b.push_back(8'h5A);
    for (int r = 0; r < 2; r++) begin
      w = regs_b[r];
      exp_b.push_back(w[31:24]); exp_b.push_back(w[23:16]);
      exp_b.push_back(w[15:8]);  exp_b.push_back(w[7:0]);
    end
  endtask

  task automatic pulse_start(input bit sel);
    @(negedge clk);
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_done(input bit sel, input int base, input int budget, input string tag);
    int n;
    n = 0;
    while (((sel ? done_cnt_b : done_cnt_a) == base) && n < budget) begin
      @(negedge clk);
      n++;
    end
    n_vec++;
    if ((sel ? done_cnt_b : done_cnt_a) == base) begin
      n_err++;
      $display("FAIL %s: no done pulse within %0d cycles", tag, budget);
    end
  endtask

  // Pops received bytes against the expected queue; leaves both empty.
  task automatic scoreboard_compare(input bit sel, input string tag);
    byte_t e, r;
    int    n_e, n_r, i;
    n_e = sel ? exp_b.size() : exp_a.size();
    n_r = sel ? rx_b.size()  : rx_a.size();
    n_vec++;
    if (n_r !== n_e) begin
      n_err++;
      $display("FAIL %s byte_count: got %0d expected %0d", tag, n_r, n_e);
    end
    n_vec++;
    if ((sel ? frame_err_b : frame_err_a) !== 0) begin
      n_err++;
      $display("FAIL %s framing: got %0d errors expected 0", tag, sel ? frame_err_b : frame_err_a);
    end
    i = 0;
    while ((sel ? exp_b.size() : exp_a.size()) > 0 && (sel ? rx_b.size() : rx_a.size()) > 0) begin
      e = sel ? exp_b.pop_front() : exp_a.pop_front();
      r = sel ? rx_b.pop_front()  : rx_a.pop_front();
      n_vec++;
      if (r !== e) begin
        n_err++;
        $display("FAIL %s byte[%0d]: got %02h expected %02h", tag, i, r, e);
      end
      i++;
    end
    if (sel) begin exp_b.delete(); rx_b.delete(); end
    else     begin exp_a.delete(); rx_a.delete(); end
  endtask

  task automatic test_reset();
    int lows;
    rstn = 1'b0;
    #15;
    n_vec += 8;
    if (tx_a !== 1'b1)       begin n_err++; $display("FAIL reset tx_a: got %b expected 1", tx_a); end
    if (busy_a !== 1'b0)     begin n_err++; $display("FAIL reset busy_a: got %b expected 0", busy_a); end
    if (reg_sel_a !== 5'd0)  begin n_err++; $display("FAIL reset reg_sel_a: got %0d expected 0", reg_sel_a); end
    if (done_a !== 1'b0)     begin n_err++; $display("FAIL reset done_a: got %b expected 0", done_a); end
    if (tx_b !== 1'b1)       begin n_err++; $display("FAIL reset tx_b: got %b expected 1", tx_b); end
    if (busy_b !== 1'b0)     begin n_err++; $display("FAIL reset busy_b: got %b expected 0", busy_b); end
    if (reg_sel_b !== 5'd0)  begin n_err++; $display("FAIL reset reg_sel_b: got %0d expected 0", reg_sel_b); end
    if (done_b !== 1'b0)     begin n_err++; $display("FAIL reset done_b: got %b expected 0", done_b); end
    #5;
    rstn = 1'b1;
    lows = 0;
    repeat (1000) begin
      @(negedge clk);
      if (tx_a !== 1'b1 || tx_b !== 1'b1 || busy_a !== 1'b0 || busy_b !== 1'b0) lows++;
    end
    n_vec++;
    if (lows !== 0) begin n_err++; $display("FAIL idle_hold: got %0d non-idle cycles expected 0", lows); end
  endtask

  int done_base_a;

  task automatic test_header_frame();
    byte_t sync;
    logic  exp_bit;
    sync = 8'h5A;
    for (int r = 0; r < 32; r++) regs_a[r] = 32'h0;
    regs_a[7] = 32'h12345678;
    done_base_a = done_cnt_a;
    @(negedge clk);
    push_expected_a();
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    n_vec += 2;
    if (busy_a !== 1'b1) begin n_err++; $display("FAIL hdr busy_after_start: got %b expected 1", busy_a); end
    if (tx_a !== 1'b1)   begin n_err++; $display("FAIL hdr accept_cycle_tx: got %b expected 1", tx_a); end
    for (int n = 2; n <= 43; n++) begin
      @(negedge clk);
      if (n <= 5)       exp_bit = 1'b0;
      else if (n <= 37) exp_bit = sync[(n - 6) / 4];
      else if (n <= 42) exp_bit = 1'b1;
      else              exp_bit = 1'b0;
      n_vec++;
      if (tx_a !== exp_bit) begin
        n_err++;
        $display("FAIL hdr tx_cycle_%0d: got %b expected %b", n, tx_a, exp_bit);
      end
    end
  endtask

  task automatic test_data_order();
    wait_done(1'b0, done_base_a, 8000, "data_order");
    repeat (50) @(negedge clk);
    scoreboard_compare(1'b0, "data_order");
    n_vec++;
    if (done_cnt_a - done_base_a !== 1) begin
      n_err++;
      $display("FAIL data_order done_pulses: got %0d expected 1", done_cnt_a - done_base_a);
    end
  endtask

  task automatic test_mutation();
    int base, n;
    for (int r = 0; r < 32; r++) regs_a[r] = 32'h0;
    regs_a[1] = 32'hDEADBEEF;
    base = done_cnt_a;
    push_expected_a();
    pulse_start(1'b0);
    n = 0;
    while (rx_a.size() < 6 && n < 2000) begin @(negedge clk); n++; end
    n_vec++;
    if (rx_a.size() < 6) begin n_err++; $display("FAIL mutation reach_reg1: got %0d bytes expected 6", rx_a.size()); end
    regs_a[1] = 32'h0;
    wait_done(1'b0, base, 8000, "mutation");
    repeat (50) @(negedge clk);
    scoreboard_compare(1'b0, "mutation");
  endtask

  task automatic test_reset_mid_dump();
    int base, n;
    for (int r = 0; r < 32; r++) regs_a[r] = {8'(r), 8'hC3, ~8'(r), 8'h3C};
    push_expected_a();
    pulse_start(1'b0);
    n = 0;
    while (rx_a.size() < 42 && n < 4000) begin @(negedge clk); n++; end
    n = 0;
    while (tx_a !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    n_vec++;
    if (tx_a !== 1'b0 || rx_a.size() < 42) begin
      n_err++;
      $display("FAIL rst_mid setup: got tx=%b bytes=%0d expected tx=0 bytes>=42", tx_a, rx_a.size());
    end
    #2 rstn = 1'b0;
    #1;
    n_vec += 3;
    if (tx_a !== 1'b1)      begin n_err++; $display("FAIL rst_mid tx_async: got %b expected 1", tx_a); end
    if (busy_a !== 1'b0)    begin n_err++; $display("FAIL rst_mid busy: got %b expected 0", busy_a); end
    if (reg_sel_a !== 5'd0) begin n_err++; $display("FAIL rst_mid reg_sel: got %0d expected 0", reg_sel_a); end
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (10) @(negedge clk);
    exp_a.delete();
    rx_a.delete();
    base = done_cnt_a;
    push_expected_a();
    pulse_start(1'b0);
    wait_done(1'b0, base, 8000, "rst_mid");
    repeat (50) @(negedge clk);
    n_vec++;
    if (rx_a.size() > 0 && rx_a[0] !== 8'h5A) begin
      n_err++;
      $display("FAIL rst_mid first_byte: got %02h expected 5a", rx_a[0]);
    end
    scoreboard_compare(1'b0, "rst_mid");
  endtask

  task automatic test_back_to_back_start();
    int base;
    regs_b[0] = 32'hA1B2C3D4;
    regs_b[1] = 32'h0F1E2D3C;
    base = done_cnt_b;
    push_expected_b();
    pulse_start(1'b1);
    repeat (50)  @(negedge clk);
    pulse_start(1'b1);
    repeat (100) @(negedge clk);
    pulse_start(1'b1);
    repeat (120) @(negedge clk);
    pulse_start(1'b1);
    wait_done(1'b1, base, 2000, "busy_ignore");
    repeat (200) @(negedge clk);
    scoreboard_compare(1'b1, "busy_ignore");
    n_vec += 4;
    if (done_cnt_b - base !== 1) begin
      n_err++; $display("FAIL busy_ignore done_pulses: got %0d expected 1", done_cnt_b - base);
    end
    if (busy_at_done_b !== 1'b0) begin
      n_err++; $display("FAIL busy_ignore busy_at_done: got %b expected 0", busy_at_done_b);
    end
    if (busy_before_done_b !== 1'b1) begin
      n_err++; $display("FAIL busy_ignore busy_before_done: got %b expected 1", busy_before_done_b);
    end
    if (busy_b !== 1'b0) begin
      n_err++; $display("FAIL busy_ignore busy_after: got %b expected 0", busy_b);
    end
  endtask

  initial begin
    start_a = 1'b0;
    start_b = 1'b0;
    for (int r = 0; r < 32; r++) regs_a[r] = 32'h0;
    regs_b[0] = 32'h0;
    regs_b[1] = 32'h0;
    test_reset();
    test_header_frame();
    test_data_order();
    test_mutation();
    test_reset_mid_dump();
    test_back_to_back_start();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
